// File: rtl/stitch_pipe_ctrl.sv
// Elastic valid/enable sequencer for a STAGES-deep register pipeline with
// RUN/DRAIN/HALT admission control and a saturating backpressure counter.
module stitch_pipe_ctrl #(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STAGES-1:0]  stage_en,
  output logic [STAGES-1:0]  stage_valid,
  input  logic               flush,
  input  logic               drain_req,
  input  logic               resume,
  input  logic               clr_stats,
  output logic               halted,
  output logic [7:0]         occupancy,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;

  state_e               state_q, state_d;
  logic [STAGES-1:0]    valid_q, valid_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 accept;
  logic [STAGES:0]      load_src;

  // Stage k is blocked only when every slot from k to the top is full and
  // the output is stalled; this is the unrolled form of the enable chain.
  always_comb begin : enable_chain
    logic        full_above;
    int unsigned k;
    full_above = ~out_ready;
    stage_en   = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      k            = STAGES - 1 - i;
      full_above   = full_above & valid_q[k];
      stage_en[k]  = ~full_above;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      occupancy = occupancy + 8'(valid_q[i]);
    end
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[STAGES-1];
  assign halted      = (state_q == HALT);
  assign stall_cnt   = stall_q;
  assign in_ready    = stage_en[0] & (state_q == RUN) & ~flush;
  assign accept      = in_valid & in_ready;
  assign load_src    = {valid_q, accept};

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (stage_en[i]) valid_d[i] = load_src[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (drain_req) state_d = flush ? HALT : DRAIN;
      DRAIN:   if (flush || occupancy == 8'd0) state_d = HALT;
      HALT:    if (resume && !drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (clr_stats) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && stall_q != '1) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      state_q <= RUN;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_stitch_pipe_ctrl.sv
// Bench for stitch_pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a slot-level model.
module tb_stitch_pipe_ctrl;

  localparam int S = 2;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         flush = 1'b0;
  logic         drain_req = 1'b0;
  logic         resume = 1'b0;
  logic         clr_stats = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [S-1:0] stage_en;
  logic [S-1:0] stage_valid;
  logic         halted;
  logic [7:0]   occupancy;
  logic [W-1:0] stall_cnt;

  always #5 clk = ~clk;

  stitch_pipe_ctrl #(.STAGES(S), .STALL_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .stage_en(stage_en),
    .stage_valid(stage_valid), .flush(flush), .drain_req(drain_req),
    .resume(resume), .clr_stats(clr_stats), .halted(halted),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one valid bit per slot, mode 0=RUN 1=DRAIN 2=HALT, plain integer
  // stall counter and word bookkeeping (accepted/delivered/dropped).
  logic [S-1:0] mv = '0;
  int           mstate = 0;
  int           mcnt = 0;
  int           acc = 0, del = 0, drop = 0;
  bit           chk_en = 0;

  function automatic logic [S-1:0] m_en(input logic [S-1:0] v, input logic ordy);
    logic [S-1:0] e;
    for (int k = 0; k < S; k++) begin
      e[k] = ordy;
      for (int j = k; j < S; j++) if (!v[j]) e[k] = 1'b1;
    end
    return e;
  endfunction

  function automatic logic m_inrdy();
    logic [S-1:0] e;
    e = m_en(mv, out_ready);
    return e[0] && mstate == 0 && !flush;
  endfunction

  function automatic logic [S-1:0] m_next();
    logic [S:0]   src;
    logic [S-1:0] e, n;
    e   = m_en(mv, out_ready);
    src = {mv, m_inrdy() & in_valid};
    n   = '0;
    if (!flush) for (int k = 0; k < S; k++) n[k] = e[k] ? src[k] : mv[k];
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      drop   <= drop + $countones(mv);
      mv     <= '0;
      mstate <= 0;
      mcnt   <= 0;
    end else begin
      mv  <= m_next();
      acc <= acc + int'(m_inrdy() & in_valid);
      del <= del + int'(mv[S-1] & out_ready);
      if (flush) drop <= drop + $countones(mv) - int'(mv[S-1] & out_ready);
      case (mstate)
        0: if (drain_req) mstate <= flush ? 2 : 1;
        1: if (flush || $countones(mv) == 0) mstate <= 2;
        default: if (resume && !drain_req) mstate <= 0;
      endcase
      if (clr_stats) mcnt <= 0;
      else if (mv[S-1] && !out_ready) mcnt <= (mcnt < (1 << W) - 1) ? mcnt + 1 : mcnt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid",   out_valid,   mv[S-1]);
      chk("stage_valid", stage_valid, mv);
      chk("stage_en",    stage_en,    m_en(mv, out_ready));
      chk("in_ready",    in_ready,    m_inrdy());
      chk("halted",      halted,      mstate == 2);
      chk("occupancy",   occupancy,   $countones(mv));
      chk("stall_cnt",   stall_cnt,   mcnt);
      chk("in_flight",   occupancy,   acc - del - drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst halted", halted, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst stage_en", stage_en, 2'b11);
    chk("rst stall_cnt", stall_cnt, 0);

    // single word, latency S
    in_valid = 1; out_ready = 1; #1;
    chk("p1 in_ready", in_ready, 1);
    tick(); in_valid = 0; #1;
    chk("p1 sv@1", stage_valid, 2'b01);
    chk("p1 ov@1", out_valid, 0);
    tick(); #1;
    chk("p1 ov@2", out_valid, 1);
    tick(); #1;
    chk("p1 ov@3", out_valid, 0);

    // backpressure fill then back-to-back drain
    out_ready = 0; in_valid = 1;
    tick(); tick(); #1;
    chk("bp in_ready", in_ready, 0);
    chk("bp occ", occupancy, 2);
    chk("bp stall0", stall_cnt, 0);
    tick(); #1;
    chk("bp stall1", stall_cnt, 1);
    tick(); #1;
    chk("bp stall2", stall_cnt, 2);
    out_ready = 1; in_valid = 0; #1;
    chk("bp out a", out_valid, 1);
    tick(); #1;
    chk("bp out b", out_valid, 1);
    tick(); #1;
    chk("bp out end", out_valid, 0);

    // bubble collapse
    in_valid = 1; out_ready = 0;
    tick(); in_valid = 0;
    tick(); in_valid = 1; #1;
    chk("bub sv", stage_valid, 2'b10);
    chk("bub in_ready", in_ready, 1);
    tick(); #1;
    chk("bub sv full", stage_valid, 2'b11);

    // flush beats acceptance
    flush = 1; #1;
    chk("fl in_ready", in_ready, 0);
    tick(); flush = 0; in_valid = 0; #1;
    chk("fl sv", stage_valid, 2'b00);
    chk("fl stall", stall_cnt, 4);

    // drain to halt, resume
    out_ready = 0; in_valid = 1;
    tick(); tick();
    in_valid = 0; out_ready = 1; drain_req = 1; #1;
    chk("dr occ2", occupancy, 2);
    tick(); drain_req = 0; in_valid = 1; #1;
    chk("dr in_ready", in_ready, 0);
    chk("dr occ1", occupancy, 1);
    tick(); #1;
    chk("dr occ0", occupancy, 0);
    chk("dr not yet halted", halted, 0);
    tick(); #1;
    chk("dr halted", halted, 1);
    chk("dr halt in_ready", in_ready, 0);
    resume = 1; drain_req = 1;
    tick(); #1;
    chk("halt both stays", halted, 1);
    drain_req = 0;
    tick(); resume = 0; in_valid = 0; #1;
    chk("resume halted", halted, 0);
    chk("resume in_ready", in_ready, 1);

    // saturation, clear, mid-stream reset
    clr_stats = 1;
    tick(); clr_stats = 0; #1;
    chk("clr stall", stall_cnt, 0);
    out_ready = 0; in_valid = 1;
    repeat (22) tick();
    #1;
    chk("sat stall", stall_cnt, 15);
    clr_stats = 1;
    tick(); clr_stats = 0; #1;
    chk("clr on stall", stall_cnt, 0);
    rst_n = 0;
    tick(); #1;
    chk("mrst out_valid", out_valid, 0);
    chk("mrst occ", occupancy, 0);
    chk("mrst halted", halted, 0);
    chk("mrst in_ready", in_ready, 1);
    chk("mrst stage_en", stage_en, 2'b11);
    chk("mrst stall", stall_cnt, 0);
    rst_n = 1; in_valid = 0; out_ready = 1;

    repeat (3000) begin
      tick();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      drain_req = ($urandom_range(0, 23) == 0);
      resume    = ($urandom_range(0, 3) == 0);
      clr_stats = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
